// File: rtl/mmio_hub.sv
// mmio_hub: CPU MMIO decoder for the RAM window, LED, GPIO with edge capture and a tick timer.
// The timer block (0x7004-0x7006 and the match irq term) exists only when MMIO_HUB_TIMER_EN is defined.
module mmio_hub #(
    parameter int GPIO_N    = 4,
    parameter int TICK_DIV  = 16000,
    parameter int RAM_WORDS = 8192
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [14:0]       address,
    input  logic [15:0]       dataIn,
    input  logic              load,
    output logic [15:0]       dataOut,
    output logic              ramLoad,
    input  logic [15:0]       ramData,
    output logic              LED,
    output logic [GPIO_N-1:0] gpioOutEn,
    output logic [GPIO_N-1:0] gpioOutSig,
    input  logic [GPIO_N-1:0] gpioInSig,
    output logic              irq
);

    localparam logic [14:0] RAM_TOP = 15'(RAM_WORDS - 1);
    localparam logic [14:0] A_LED   = 15'h7000;
    localparam logic [14:0] A_GIO   = 15'h7001;
    localparam logic [14:0] A_DIR   = 15'h7002;
    localparam logic [14:0] A_EDGE  = 15'h7003;
    localparam logic [14:0] A_CNT   = 15'h7004;
    localparam logic [14:0] A_CMP   = 15'h7005;
    localparam logic [14:0] A_CTL   = 15'h7006;

    logic              ram_sel;
    logic              led_q;
    logic              irq_q;
    logic [GPIO_N-1:0] out_q;
    logic [GPIO_N-1:0] dir_q;
    logic [GPIO_N-1:0] sync1_q;
    logic [GPIO_N-1:0] sync2_q;
    logic [GPIO_N-1:0] prev_q;
    logic [GPIO_N-1:0] edge_q;
    logic [GPIO_N-1:0] rise;
    logic [GPIO_N-1:0] edge_clr;
    logic [2:0]        vld_q;
    logic              irq_match;
    logic              gpio_irq_en;
    logic [15:0]       rdata;

    assign ram_sel    = (address <= RAM_TOP);
    assign ramLoad    = load & ram_sel;
    assign LED        = led_q;
    assign gpioOutEn  = dir_q;
    assign gpioOutSig = out_q;
    assign irq        = irq_q;

    // prev_q only holds a real synchronized sample once vld_q[2] is set, so reset values never look like edges.
    assign rise     = sync2_q & ~prev_q & ~dir_q & {GPIO_N{vld_q[2]}};
    assign edge_clr = (load && address == A_EDGE) ? dataIn[GPIO_N-1:0] : '0;

`ifdef MMIO_HUB_TIMER_EN
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

    logic [15:0]   cnt_q;
    logic [15:0]   cmp_q;
    logic [15:0]   cnt_inc;
    logic [PW-1:0] pre_q;
    logic [3:1]    ctl_q;
    logic          match_q;
    logic          tick;
    logic          wr_cnt;
    logic          wr_ctl;

    assign wr_cnt      = load && (address == A_CNT);
    assign wr_ctl      = load && (address == A_CTL);
    assign tick        = ctl_q[1] && (pre_q == PRE_TOP);
    assign cnt_inc     = cnt_q + 16'd1;
    assign irq_match   = match_q & ctl_q[2];
    assign gpio_irq_en = ctl_q[3];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt_q   <= '0;
            cmp_q   <= 16'hFFFF;
            pre_q   <= '0;
            ctl_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (wr_ctl)
                ctl_q <= dataIn[3:1];
            if (load && address == A_CMP)
                cmp_q <= dataIn;
            if (wr_cnt) begin
                cnt_q <= dataIn;
                pre_q <= '0;
            end else begin
                if (tick)
                    cnt_q <= cnt_inc;
                if (!ctl_q[1] || tick || (wr_ctl && !dataIn[1]))
                    pre_q <= '0;
                else
                    pre_q <= pre_q + PW'(1);
            end
            if (tick && !wr_cnt && cnt_inc == cmp_q)
                match_q <= 1'b1;
            else if (wr_ctl && dataIn[0])
                match_q <= 1'b0;
        end
    end
`else
    // Without the timer there is no control register, so edge status drives irq directly.
    logic unused_din;
    assign unused_din  = ^dataIn;
    assign irq_match   = 1'b0;
    assign gpio_irq_en = 1'b1;
`endif

    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = ramData;
        end else begin
            case (address)
                A_LED:  rdata = {15'b0, led_q};
                A_GIO:  rdata = 16'(sync2_q);
                A_DIR:  rdata = 16'(dir_q);
                A_EDGE: rdata = 16'(edge_q);
`ifdef MMIO_HUB_TIMER_EN
                A_CNT:  rdata = cnt_q;
                A_CMP:  rdata = cmp_q;
                A_CTL:  rdata = {12'b0, ctl_q, match_q};
`endif
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            led_q   <= 1'b0;
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            vld_q   <= '0;
            edge_q  <= '0;
            irq_q   <= 1'b0;
            dataOut <= '0;
        end else begin
            sync1_q <= gpioInSig;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            vld_q   <= {vld_q[1:0], 1'b1};
            if (load && address == A_LED)
                led_q <= dataIn[0];
            if (load && address == A_GIO)
                out_q <= dataIn[GPIO_N-1:0];
            if (load && address == A_DIR)
                dir_q <= dataIn[GPIO_N-1:0];
            edge_q  <= (edge_q & ~edge_clr) | rise;
            irq_q   <= irq_match | ((|edge_q) & gpio_irq_en);
            dataOut <= rdata;
        end
    end

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 SHALL have parameter GPIO_N, default 4, number of GPIO channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 16000, CLK cycles per timer tick (>=2).
REQ-003 SHALL have parameter RAM_WORDS, default 8192, RAM window size in words (power of 2, <=16384).
REQ-004 SHALL have ports: CLK  in  1  system clock; RESET_N  in  1  synchronous active-low reset; address  in  15  CPU word address; dataIn  in  16  CPU write data; load  in  1  CPU write strobe; dataOut  out  16  registered read data.
REQ-005 SHALL have ports: ramLoad  out  1  RAM write enable; ramData  in  16  RAM read data; LED  out  1  on-board LED; gpioOutEn  out  GPIO_N  per-pin output enable; gpioOutSig  out  GPIO_N  per-pin drive value; gpioInSig  in  GPIO_N  raw pin inputs; irq  out  1  level interrupt.
REQ-006 Reset SHALL be synchronous and active-low on RESET_N, with a single clock, CLK.

Function
REQ-007 Address map SHALL be: 0x0000..RAM_WORDS-1 RAM; 0x7000 LED (bit0); 0x7001 GPIO out/in; 0x7002 GPIO direction (1=out); 0x7003 GPIO edge status; 0x7004 timer count; 0x7005 timer compare; 0x7006 timer control/status.
REQ-008 ramLoad SHALL equal load when address < RAM_WORDS, else 0; combinational.
REQ-009 dataOut SHALL be registered: value reflects address presented in cycle N, valid in cycle N+1.
REQ-010 Reads of unmapped addresses SHALL return 0x0000; unused upper bits of narrow registers SHALL read 0.
REQ-011 Writes SHALL take effect on the CLK edge where load=1; writes to read-only or unmapped addresses SHALL be ignored.
REQ-012 gpioInSig SHALL pass a 2-flop synchronizer; 0x7001 read returns the synchronized value on all pins.
REQ-013 gpioOutEn SHALL equal the direction register; gpioOutSig SHALL equal the output register.
REQ-014 Edge status bit k SHALL set on a rising edge of synchronized pin k (prior-cycle vs current) when pin k is an input; sticky until cleared.
REQ-015 Writing 1 to edge status bit k SHALL clear it; set-on-edge in the same cycle SHALL win over clear.
REQ-016 Prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap, only while control bit1 (enable)=1; clearing enable SHALL reset prescaler to 0.
REQ-017 Timer count (16 bit) SHALL increment per tick, wrapping 0xFFFF->0x0000; CPU write to 0x7004 SHALL load count and reset prescaler, overriding a same-cycle tick.
REQ-018 Match flag (control bit0) SHALL set when a tick makes count equal compare; write 1 to bit0 clears; same-cycle set wins.
REQ-019 Control write SHALL update bit1 from dataIn[1]; bit0 only W1C per REQ-018.
REQ-020 irq SHALL be registered: (match flag AND control bit2 irq-enable) OR (any edge status bit AND control bit3 gpio-irq-enable).

Reset
REQ-021 On RESET_N=0 at CLK edge: dataOut, LED, gpioOutEn, gpioOutSig, edge status, synchronizers, prescaler, count, control, irq SHALL be 0; compare SHALL be 0xFFFF.
REQ-022 Reset asserted mid-operation SHALL override any same-cycle write or tick.
REQ-023 First edge detection after reset SHALL require two synchronized samples (no edge from reset value).

Configuration
REQ-024 Macro MMIO_HUB_TIMER_EN defined: timer, prescaler, 0x7004-0x7006 and match irq term SHALL exist per REQ-016..020.
REQ-025 MMIO_HUB_TIMER_EN undefined: timer logic SHALL be absent, 0x7004-0x7006 read 0 and ignore writes, irq depends only on GPIO term.

Verification
REQ-026 Write 0x0005 to 0x7002, 0x000F to 0x7001 -> gpioOutEn=0101, gpioOutSig=1111 next cycle; read 0x7001 returns synchronized pins one cycle after address.
REQ-027 Pin1 input 0->1 -> edge status reads 0x0002 within 3 cycles; W1C 0x0002 in same cycle as new pin1 edge -> bit stays 1.
REQ-028 TICK_DIV=4, compare=3, control=0x0006 -> count=3 after 12 enabled cycles, match flag=1, irq=1 one cycle later; W1C bit0 -> irq=0.
REQ-029 Count loaded 0xFFFF, one tick -> count=0x0000, no match unless compare=0.
REQ-030 Write address 0x0100 with load=1 -> ramLoad=1; address 0x4000 with load=1 -> ramLoad=0, no state changes, read returns 0x0000.
REQ-031 RESET_N low during active timer and pending edges -> all REQ-021 values next cycle; without MMIO_HUB_TIMER_EN, read 0x7004 -> 0x0000.
